// File: rtl/mcpu_pkg.sv
// Shared defaults for the MicroCPU unified memory: word width, address width
// and the derived number of words.
package mcpu_pkg;

   localparam int MCPU_WORD_SIZE  = 8;
   localparam int MCPU_ADDR_WIDTH = 8;
   localparam int MCPU_RAM_SIZE   = 1 << MCPU_ADDR_WIDTH;

endpackage

// File: rtl/mcpu_ram_array.sv
// Storage array with one clocked write port, asynchronous clear and two
// combinational read ports; the array itself is exported for the top level.
module mcpu_ram_array
   import mcpu_pkg::*;
#(
   parameter int WORD_SIZE  = MCPU_WORD_SIZE,
   parameter int ADDR_WIDTH = MCPU_ADDR_WIDTH,
   parameter int RAM_SIZE   = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WORD_SIZE-1:0]  wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   output logic [WORD_SIZE-1:0]  rd_data_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [WORD_SIZE-1:0]  rd_data_b,
   output logic [WORD_SIZE-1:0]  mem [RAM_SIZE-1:0]
);

   // Reset clears every word at once, so a write pending at reset is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '{default: '0};
      end else if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = mem[rd_addr_a];
   assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/mcpu_ram_controller.sv
// Unified instruction/data memory: data port with read enable gating and an
// always-enabled instruction fetch port sharing one array.
module mcpu_ram_controller
   import mcpu_pkg::*;
#(
   parameter int WORD_SIZE  = MCPU_WORD_SIZE,
   parameter int ADDR_WIDTH = MCPU_ADDR_WIDTH,
   parameter int RAM_SIZE   = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [WORD_SIZE-1:0]  datawr,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [WORD_SIZE-1:0]  datard,
   input  logic [ADDR_WIDTH-1:0] instraddr,
   output logic [WORD_SIZE-1:0]  instrrd
);

   logic [WORD_SIZE-1:0] mem [RAM_SIZE-1:0];
   logic [WORD_SIZE-1:0] data_word;

   mcpu_ram_array #(
      .WORD_SIZE  (WORD_SIZE),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RAM_SIZE   (RAM_SIZE)
   ) u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .wr_addr   (addr),
      .wr_data   (datawr),
      .rd_addr_a (addr),
      .rd_data_a (data_word),
      .rd_addr_b (instraddr),
      .rd_data_b (instrrd),
      .mem       (mem)
   );

   // The data port drives zero whenever it is not being read.
   assign datard = re ? data_word : '0;

endmodule

// File: tb/tb_mcpu_ram_controller.sv
// Self-checking bench for mcpu_ram_controller using a shadow memory model
// and randomized write data.
module tb_mcpu_ram_controller;

   logic       clk;
   logic       rst_n;
   logic       we;
   logic [7:0] datawr;
   logic       re;
   logic [7:0] addr;
   logic [7:0] datard;
   logic [7:0] instraddr;
   logic [7:0] instrrd;

   logic [7:0] shadow [256];
   int compared;
   int mismatched;

   mcpu_ram_controller dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .datawr    (datawr),
      .re        (re),
      .addr      (addr),
      .datard    (datard),
      .instraddr (instraddr),
      .instrrd   (instrrd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic write_word(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      we     = 1'b1;
      addr   = a;
      datawr = d;
      @(posedge clk);
      #1;
      shadow[a] = d;
      we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      re        = 1'b1;
      addr      = 8'h00;
      instraddr = 8'hFF;
      #1;
      compared++;
      if (datard !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_datard got %h expected 00", datard);
      end
      compared++;
      if (instrrd !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL reset_instrrd got %h expected 00", instrrd);
      end
      for (int i = 0; i < 256; i++) begin
         shadow[i] = 8'h00;
         compared++;
         if (dut.mem[i] !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_mem[%0d] got %h expected 00", i, dut.mem[i]);
         end
      end
   endtask

   task automatic test_write_sweep();
      for (int i = 0; i < 256; i++) begin
         write_word(i[7:0], 8'($urandom));
      end
      for (int i = 0; i < 256; i++) begin
         compared++;
         if (dut.mem[i] !== shadow[i]) begin
            mismatched++;
            $display("[TB] FAIL sweep_mem[%0d] got %h expected %h", i, dut.mem[i], shadow[i]);
         end
      end
   endtask

   task automatic test_dual_readback();
      logic [7:0] a;
      logic [7:0] b;
      we = 1'b0;
      re = 1'b1;
      for (int i = 0; i < 256; i++) begin
         addr      = i[7:0];
         instraddr = i[7:0];
         #1;
         compared++;
         if (datard !== shadow[i] || instrrd !== shadow[i]) begin
            mismatched++;
            $display("[TB] FAIL readback[%0d] got d=%h i=%h expected %h", i, datard, instrrd, shadow[i]);
         end
      end
      for (int i = 0; i < 64; i++) begin
         a         = 8'($urandom);
         b         = 8'($urandom);
         re        = 1'($urandom);
         addr      = a;
         instraddr = b;
         #1;
         compared++;
         if (datard !== (re ? shadow[a] : 8'h00) || instrrd !== shadow[b]) begin
            mismatched++;
            $display("[TB] FAIL random_read a=%h b=%h re=%b got d=%h i=%h expected d=%h i=%h",
                     a, b, re, datard, instrrd, re ? shadow[a] : 8'h00, shadow[b]);
         end
      end
      re = 1'b1;
   endtask

   task automatic test_independent_ports();
      write_word(8'h10, 8'hA5);
      write_word(8'h20, 8'h3C);
      re        = 1'b1;
      addr      = 8'h10;
      instraddr = 8'h20;
      #1;
      compared++;
      if (datard !== 8'hA5 || instrrd !== 8'h3C) begin
         mismatched++;
         $display("[TB] FAIL independent got d=%h i=%h expected d=a5 i=3c", datard, instrrd);
      end
      addr      = 8'h20;
      instraddr = 8'h10;
      #1;
      compared++;
      if (datard !== 8'h3C || instrrd !== 8'hA5) begin
         mismatched++;
         $display("[TB] FAIL independent_swap got d=%h i=%h expected d=3c i=a5", datard, instrrd);
      end
   endtask

   task automatic test_re_gating();
      addr      = 8'h10;
      instraddr = 8'h10;
      re        = 1'b0;
      #1;
      compared++;
      if (datard !== 8'h00 || instrrd !== shadow[8'h10]) begin
         mismatched++;
         $display("[TB] FAIL re_low got d=%h i=%h expected d=00 i=%h", datard, instrrd, shadow[8'h10]);
      end
      re = 1'b1;
      #1;
      compared++;
      if (datard !== 8'hA5) begin
         mismatched++;
         $display("[TB] FAIL re_high got %h expected a5", datard);
      end
   endtask

   task automatic test_collision();
      write_word(8'h40, 8'h11);
      @(negedge clk);
      re        = 1'b1;
      we        = 1'b1;
      addr      = 8'h40;
      instraddr = 8'h40;
      datawr    = 8'hEE;
      #1;
      compared++;
      if (datard !== 8'h11 || instrrd !== 8'h11) begin
         mismatched++;
         $display("[TB] FAIL collision_before got d=%h i=%h expected 11", datard, instrrd);
      end
      @(posedge clk);
      #1;
      shadow[8'h40] = 8'hEE;
      we = 1'b0;
      compared++;
      if (datard !== 8'hEE || instrrd !== 8'hEE) begin
         mismatched++;
         $display("[TB] FAIL collision_after got d=%h i=%h expected ee", datard, instrrd);
      end
   endtask

   task automatic test_mid_reset();
      int nonzero;
      @(negedge clk);
      we        = 1'b1;
      re        = 1'b1;
      addr      = 8'h10;
      instraddr = 8'h20;
      datawr    = 8'h77;
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
      compared++;
      if (datard !== 8'h00 || instrrd !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_outputs got d=%h i=%h expected 00", datard, instrrd);
      end
      @(posedge clk);
      #1;
      nonzero = 0;
      for (int i = 0; i < 256; i++) if (dut.mem[i] !== 8'h00) nonzero++;
      compared++;
      if (nonzero != 0) begin
         mismatched++;
         $display("[TB] FAIL mid_reset_mem got %0d nonzero words expected 0", nonzero);
      end
      @(negedge clk);
      we    = 1'b0;
      rst_n = 1'b1;
      #1;
      compared++;
      if (dut.mem[8'h10] !== 8'h00 || instrrd !== 8'h00) begin
         mismatched++;
         $display("[TB] FAIL after_release got mem=%h i=%h expected 00", dut.mem[8'h10], instrrd);
      end
      write_word(8'h20, 8'h5A);
      #1;
      compared++;
      if (instrrd !== shadow[8'h20] || dut.mem[8'h20] !== 8'h5A) begin
         mismatched++;
         $display("[TB] FAIL first_write got i=%h expected 5a", instrrd);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      we         = 1'b0;
      re         = 1'b0;
      datawr     = 8'h00;
      addr       = 8'h00;
      instraddr  = 8'h00;
      test_reset();
      test_write_sweep();
      test_dual_readback();
      test_independent_ports();
      test_re_gating();
      test_collision();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mcpu_ram_controller.md
# mcpu_ram_controller

Unified instruction/data memory for the MicroCPU core, with one synchronous write port and two independent asynchronous read ports. The data port serves load/store traffic from the execute stage. The instruction port serves the fetch stage. Both ports share one storage array, so code and data live in the same address space.

## Interface
Parameters:
- WORD_SIZE, 8, bits per memory word.
- ADDR_WIDTH, 8, address bits for both ports.
- RAM_SIZE, 1<<ADDR_WIDTH, number of words; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all writes are captured on its rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- we  input  1  write enable for the data port.
- datawr  input  WORD_SIZE  write data.
- re  input  1  read enable for the data port.
- addr  input  ADDR_WIDTH  data-port address, shared by reads and writes.
- datard  output  WORD_SIZE  data-port read result.
- instraddr  input  ADDR_WIDTH  instruction-port address.
- instrrd  output  WORD_SIZE  instruction-port read result.

The storage array is named mem, declared [WORD_SIZE-1:0] mem[RAM_SIZE-1:0]. Benches may access it hierarchically, for backdoor reads and preloading.

## Operation
- Write: on a rising clk edge with rst_n=1 and we=1, mem[addr] <= datawr. When we=0, mem is unchanged.
- Data read is combinational:
  - re=1: datard = mem[addr].
  - re=0: datard = 0.
- Instruction read is combinational and always enabled: instrrd = mem[instraddr].
- The two read ports are fully independent. Equal addresses on both ports are legal and return the same word.
- A write and a read to the same address in the same cycle:
  - Before the edge, the read returns the old word.
  - After the edge settles, both read ports return the new word (no bypass needed).
- re and we may be asserted together. The write still occurs, and datard shows the stored value.
- Addresses cover the full 2**ADDR_WIDTH range. No out-of-range case exists, and no wrap logic is needed.
- Reset (rst_n=0, asynchronous): every mem word is cleared to 0 immediately.
  - While rst_n=0, writes are ignored and instrrd reads 0.
  - datard reads 0 in every case.

## Timing
- Write latency: data is visible on the read ports after the first rising clk edge with we=1, within combinational delay.
- Read latency: zero cycles. Outputs follow address, re and mem changes combinationally, with no clock dependence.
- Reset values: mem = all zero; datard = 0; instrrd = 0.
- Deassertion of rst_n is not clocked. The first write can occur on the first rising edge after deassertion.
- There is no handshake: no ready/valid and no stall. Every write completes in one cycle.

## Structure
- Shared package mcpu_pkg holds WORD_SIZE and ADDR_WIDTH defaults, and the derived RAM_SIZE.
- One sub-module is natural: mcpu_ram_array. It holds the mem array, the clocked write and the reset clear, and exposes two combinational read ports.
  - The top-level keeps the re gating of datard.
  - The array must remain reachable as mem at the top level, either by declaring it there or by aliasing it. The top-level declaration is preferred.

## Test plan
- Reset: hold rst_n=0 for 2 cycles, then release.
  - Required: datard=0 (re=1, addr=0x00), and instrrd=0 (instraddr=0xFF).
  - Required: mem[0..255] are all 0.
- Full write sweep: we=1, addr 0x00..0xFF, one write per clk, with random datawr; keep a shadow copy.
  - Required: mem matches the shadow copy for all 256 entries, checked by backdoor read.
- Dual-port readback: we=0, re=1, step addr and instraddr together through 0x00..0xFF.
  - Required: at each step, datard == shadow[addr] and instrrd == shadow[instraddr].
- Independent ports: write 0xA5 at 0x10 and 0x3C at 0x20, then set addr=0x10, instraddr=0x20.
  - Required: datard=0xA5, instrrd=0x3C.
  - Then swap the addresses. Required: datard=0x3C, instrrd=0xA5.
- Read enable gating: addr=0x10 holding 0xA5.
  - re=0 → datard=0x00 while instrrd (instraddr=0x10) still equals 0xA5.
  - re=1 → datard=0xA5.
- Write/read collision: addr=instraddr=0x40, old word 0x11, with we=1 and datawr=0xEE.
  - Required before the edge: both outputs read 0x11.
  - Required after the edge: both outputs read 0xEE.
- Mid-operation reset: assert rst_n=0 between clk edges while we=1.
  - Required: outputs read 0 immediately.
  - Required: the pending write is dropped, and mem stays 0 until release.
